// File: rtl/cmul_int_dump.sv
`default_nettype none
// ============================================================================
// Module   : cmul_int_dump
// Purpose  : Complex integrate-and-dump after the 16-bit complex multiplier.
//            Sums a block of IQ beats, rounds and right-shifts the sums, and
//            emits one IQ sample per block. Optional macro INTDUMP_SATURATE_EN
//            clips the output instead of wrapping it.
// Revision : 1.0 - initial release
// ============================================================================
module cmul_int_dump #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 16,
    parameter int ACC_WIDTH = 32,
    parameter int LEN_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LEN_WIDTH-1:0]   dump_len,
    input  logic [5:0]             shift,
    input  logic [2*WIDTH_IN-1:0]  i_tdata,
    input  logic                   i_tlast,
    input  logic                   i_tvalid,
    output logic                   i_tready,
    output logic [2*WIDTH_OUT-1:0] o_tdata,
    output logic                   o_tlast,
    output logic                   o_tvalid,
    input  logic                   o_tready
);

    localparam int                 c_ext     = ACC_WIDTH - WIDTH_IN;
    localparam logic [LEN_WIDTH-1:0] c_len_one = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    logic [ACC_WIDTH-1:0]   r_acc_i;
    logic [ACC_WIDTH-1:0]   r_acc_q;
    logic [LEN_WIDTH-1:0]   r_cnt;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [5:0]             r_shift;
    logic [2*WIDTH_OUT-1:0] r_o_tdata;
    logic                   r_o_tlast;
    logic                   r_o_tvalid;

    logic                   w_block_start;
    logic [LEN_WIDTH-1:0]   w_len;
    logic [LEN_WIDTH-1:0]   w_len_eff;
    logic [5:0]             w_shift;
    logic                   w_beat;
    logic                   w_dump;
    logic [ACC_WIDTH-1:0]   w_in_i;
    logic [ACC_WIDTH-1:0]   w_in_q;
    logic [ACC_WIDTH-1:0]   w_sum_i;
    logic [ACC_WIDTH-1:0]   w_sum_q;
    logic [ACC_WIDTH:0]     w_rnd;
    logic signed [ACC_WIDTH:0] w_y_i;
    logic signed [ACC_WIDTH:0] w_y_q;
    logic [WIDTH_OUT-1:0]   w_out_i;
    logic [WIDTH_OUT-1:0]   w_out_q;

    assign i_tready = !r_o_tvalid || o_tready;
    assign o_tdata  = r_o_tdata;
    assign o_tlast  = r_o_tlast;
    assign o_tvalid = r_o_tvalid;

    // The first beat of a block sees the live settings, later beats the latched ones.
    assign w_block_start = (r_cnt == '0);
    assign w_len         = w_block_start ? dump_len : r_len;
    assign w_len_eff     = (w_len == '0) ? c_len_one : w_len;
    assign w_shift       = w_block_start ? shift : r_shift;

    assign w_beat = i_tvalid && i_tready;
    assign w_dump = w_beat && ((r_cnt == (w_len_eff - c_len_one)) || i_tlast);

    assign w_in_i  = {{c_ext{i_tdata[2*WIDTH_IN-1]}}, i_tdata[2*WIDTH_IN-1:WIDTH_IN]};
    assign w_in_q  = {{c_ext{i_tdata[WIDTH_IN-1]}}, i_tdata[WIDTH_IN-1:0]};
    assign w_sum_i = r_acc_i + w_in_i;
    assign w_sum_q = r_acc_q + w_in_q;

    // One guard bit keeps the rounding add from wrapping at full-scale sums.
    assign w_rnd = (w_shift == 6'd0) ? '0
                 : ({{ACC_WIDTH{1'b0}}, 1'b1} << (w_shift - 6'd1));
    assign w_y_i = $signed({w_sum_i[ACC_WIDTH-1], w_sum_i} + w_rnd) >>> w_shift;
    assign w_y_q = $signed({w_sum_q[ACC_WIDTH-1], w_sum_q} + w_rnd) >>> w_shift;

`ifdef INTDUMP_SATURATE_EN
    function automatic logic [WIDTH_OUT-1:0] fit_out(input logic signed [ACC_WIDTH:0] y);
        if ((y[ACC_WIDTH:WIDTH_OUT-1] == '0) || (y[ACC_WIDTH:WIDTH_OUT-1] == '1))
            return y[WIDTH_OUT-1:0];
        else if (y[ACC_WIDTH])
            return {1'b1, {(WIDTH_OUT-1){1'b0}}};
        else
            return {1'b0, {(WIDTH_OUT-1){1'b1}}};
    endfunction

    assign w_out_i = fit_out(w_y_i);
    assign w_out_q = fit_out(w_y_q);
`else
    logic w_unused_hi;

    assign w_out_i     = w_y_i[WIDTH_OUT-1:0];
    assign w_out_q     = w_y_q[WIDTH_OUT-1:0];
    assign w_unused_hi = ^{w_y_i[ACC_WIDTH:WIDTH_OUT], w_y_q[ACC_WIDTH:WIDTH_OUT]};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_i    <= '0;
            r_acc_q    <= '0;
            r_cnt      <= '0;
            r_len      <= '0;
            r_shift    <= '0;
            r_o_tdata  <= '0;
            r_o_tlast  <= 1'b0;
            r_o_tvalid <= 1'b0;
        end else begin
            if (w_beat) begin
                if (w_block_start) begin
                    r_len   <= dump_len;
                    r_shift <= shift;
                end
                if (w_dump) begin
                    r_acc_i <= '0;
                    r_acc_q <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_acc_i <= w_sum_i;
                    r_acc_q <= w_sum_q;
                    r_cnt   <= r_cnt + c_len_one;
                end
            end
            // A dump coinciding with o_tready reloads the slot without a bubble.
            if (w_dump) begin
                r_o_tvalid <= 1'b1;
                r_o_tdata  <= {w_out_i, w_out_q};
                r_o_tlast  <= i_tlast;
            end else if (o_tready) begin
                r_o_tvalid <= 1'b0;
                r_o_tdata  <= '0;
                r_o_tlast  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmul_int_dump.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmul_int_dump
// Purpose  : Self-checking bench for cmul_int_dump with a block-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmul_int_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] dump_len;
    logic [5:0]  shift;
    logic [31:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;

    int n_pass  = 0;
    int n_total = 0;

    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];
    bit          rand_ready = 1'b0;

    longint m_si, m_sq;
    int     m_cnt, m_len, m_sh;

    cmul_int_dump dut (
        .clk      (clk),
        .reset    (reset),
        .dump_len (dump_len),
        .shift    (shift),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!reset && o_tvalid && o_tready)
            got_q.push_back({o_tlast, o_tdata});

    always @(posedge clk) begin
        #1;
        if (rand_ready) o_tready = ($urandom_range(0, 3) != 0);
    end

    // Reference: round half up, arithmetic shift, then clip or wrap to 16 bits.
    function automatic logic [15:0] model_fit(input longint s, input int sh);
        longint y;
        y = (sh == 0) ? s : ((s + (longint'(1) <<< (sh - 1))) >>> sh);
`ifdef INTDUMP_SATURATE_EN
        if (y > 32767) y = 32767;
        else if (y < -32768) y = -32768;
`endif
        return y[15:0];
    endfunction

    function automatic void model_clear();
        m_si = 0; m_sq = 0; m_cnt = 0; m_len = 1; m_sh = 0;
    endfunction

    function automatic void model_beat(input logic [15:0] i, input logic [15:0] q,
                                       input logic last, input int dl, input int sh);
        if (m_cnt == 0) begin
            m_len = (dl == 0) ? 1 : dl;
            m_sh  = sh;
        end
        m_si += longint'($signed(i));
        m_sq += longint'($signed(q));
        m_cnt++;
        if (m_cnt == m_len || last) begin
            exp_q.push_back({last, model_fit(m_si, m_sh), model_fit(m_sq, m_sh)});
            m_si = 0; m_sq = 0; m_cnt = 0;
        end
    endfunction

    task automatic send(input logic [15:0] i, input logic [15:0] q, input logic last);
        bit ok;
        int dl, sh;
        dl = int'(dump_len);
        sh = int'(shift);
        ok = 1'b0;
        i_tvalid = 1'b1;
        i_tdata  = {i, q};
        i_tlast  = last;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            ok = i_tready;
            @(posedge clk);
            #1;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        if (ok) model_beat(i, q, last, dl, sh);
        else begin
            n_total++;
            $display("FAIL send_timeout: i_tready stayed %0b, required 1", i_tready);
        end
    endtask

    task automatic start_test();
        repeat (2) @(posedge clk);
        #1;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; i_tvalid = 1'b0; i_tlast = 1'b0; i_tdata = '0;
        o_tready = 1'b1; dump_len = 16'd4; shift = 6'd0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (o_tvalid !== 1'b0) $display("FAIL reset_tvalid got %b exp 0", o_tvalid); else n_pass++;
        n_total++; if (o_tlast !== 1'b0) $display("FAIL reset_tlast got %b exp 0", o_tlast); else n_pass++;
        n_total++; if (o_tdata !== 32'h0) $display("FAIL reset_tdata got %h exp 0", o_tdata); else n_pass++;
        n_total++; if (i_tready !== 1'b1) $display("FAIL reset_tready got %b exp 1", i_tready); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        start_test();
        dump_len = 16'd4; shift = 6'd2; o_tready = 1'b1;
        repeat (3) send(16'd100, 16'hFF9C, 1'b0);
        n_total++; if (o_tvalid !== 1'b0) $display("FAIL basic_early got %b exp 0", o_tvalid); else n_pass++;
        send(16'd100, 16'hFF9C, 1'b0);
        n_total++; if (o_tvalid !== 1'b1) $display("FAIL basic_latency got %b exp 1", o_tvalid); else n_pass++;
        n_total++; if (o_tdata !== {16'd100, 16'hFF9C}) $display("FAIL basic_data got %h exp %h", o_tdata, {16'd100, 16'hFF9C}); else n_pass++;
        n_total++; if (o_tlast !== 1'b0) $display("FAIL basic_tlast got %b exp 0", o_tlast); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) $display("FAIL basic_model got %0d items exp 1", got_q.size()); else n_pass++;
    endtask

    task automatic test_tlast();
        start_test();
        dump_len = 16'd8; shift = 6'd0; o_tready = 1'b1;
        send(16'd1, 16'd1, 1'b0);
        send(16'd1, 16'd1, 1'b0);
        send(16'd1, 16'd1, 1'b1);
        repeat (8) send(16'd1, 16'd1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (got_q.size() != 2) $display("FAIL tlast_count got %0d exp 2", got_q.size());
        else begin
            n_pass++;
            n_total++; if (got_q[0] !== {1'b1, 16'd3, 16'd3}) $display("FAIL tlast_early got %h exp %h", got_q[0], {1'b1, 16'd3, 16'd3}); else n_pass++;
            n_total++; if (got_q[1] !== {1'b0, 16'd8, 16'd8}) $display("FAIL tlast_next got %h exp %h", got_q[1], {1'b0, 16'd8, 16'd8}); else n_pass++;
            for (int k = 0; k < 2; k++) begin
                n_total++; if (got_q[k] !== exp_q[k]) $display("FAIL tlast_model[%0d] got %h exp %h", k, got_q[k], exp_q[k]); else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        start_test();
        dump_len = 16'd1; shift = 6'd0; o_tready = 1'b0;
        send(16'd7, 16'd9, 1'b0);
        i_tvalid = 1'b1;
        i_tdata  = {16'd11, 16'd13};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_total++; if (i_tready !== 1'b0) $display("FAIL bp_tready[%0d] got %b exp 0", c, i_tready); else n_pass++;
            n_total++; if (o_tdata !== {16'd7, 16'd9}) $display("FAIL bp_hold[%0d] got %h exp %h", c, o_tdata, {16'd7, 16'd9}); else n_pass++;
            @(posedge clk);
        end
        #1;
        o_tready = 1'b1;
        send(16'd11, 16'd13, 1'b0);
        send(16'd15, 16'd17, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        n_total++;
        if (got_q.size() != 3) $display("FAIL bp_count got %0d exp 3", got_q.size());
        else begin
            n_pass++;
            for (int k = 0; k < 3; k++) begin
                n_total++; if (got_q[k] !== exp_q[k]) $display("FAIL bp_order[%0d] got %h exp %h", k, got_q[k], exp_q[k]); else n_pass++;
            end
        end
    endtask

    task automatic test_saturate();
        logic [15:0] exp_i;
`ifdef INTDUMP_SATURATE_EN
        exp_i = 16'h7FFF;
`else
        exp_i = 16'hFFFC;
`endif
        start_test();
        dump_len = 16'd4; shift = 6'd0; o_tready = 1'b1;
        repeat (4) send(16'h7FFF, 16'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (got_q.size() != 1) $display("FAIL sat_count got %0d exp 1", got_q.size());
        else begin
            n_pass++;
            n_total++; if (got_q[0][31:16] !== exp_i) $display("FAIL sat_i got %h exp %h", got_q[0][31:16], exp_i); else n_pass++;
            n_total++; if (got_q[0] !== exp_q[0]) $display("FAIL sat_model got %h exp %h", got_q[0], exp_q[0]); else n_pass++;
        end
    endtask

    task automatic test_rounding();
        start_test();
        dump_len = 16'd1; shift = 6'd1; o_tready = 1'b1;
        send(16'd3, 16'hFFFD, 1'b0);
        send(16'hFFFD, 16'd3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (got_q.size() != 2) $display("FAIL round_count got %0d exp 2", got_q.size());
        else begin
            n_pass++;
            n_total++; if (got_q[0][31:0] !== {16'd2, 16'hFFFF}) $display("FAIL round_pos got %h exp %h", got_q[0][31:0], {16'd2, 16'hFFFF}); else n_pass++;
            n_total++; if (got_q[1][31:0] !== {16'hFFFF, 16'd2}) $display("FAIL round_neg got %h exp %h", got_q[1][31:0], {16'hFFFF, 16'd2}); else n_pass++;
        end
    endtask

    task automatic test_reset_midblock();
        start_test();
        dump_len = 16'd4; shift = 6'd0; o_tready = 1'b1;
        send(16'd5, 16'd5, 1'b0);
        send(16'd5, 16'd5, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        got_q.delete();
        exp_q.delete();
        n_total++; if (o_tvalid !== 1'b0) $display("FAIL rst_mid_tvalid got %b exp 0", o_tvalid); else n_pass++;
        send(16'd1, 16'd1, 1'b0);
        dump_len = 16'd2;
        send(16'd1, 16'd1, 1'b0);
        n_total++; if (o_tvalid !== 1'b0) $display("FAIL len_change_early got %b exp 0", o_tvalid); else n_pass++;
        send(16'd1, 16'd1, 1'b0);
        send(16'd1, 16'd1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (got_q.size() != 1) $display("FAIL rst_mid_count got %0d exp 1", got_q.size());
        else begin
            n_pass++;
            n_total++; if (got_q[0] !== {1'b0, 16'd4, 16'd4}) $display("FAIL rst_mid_sum got %h exp %h", got_q[0], {1'b0, 16'd4, 16'd4}); else n_pass++;
        end
    endtask

    task automatic test_random();
        start_test();
        rand_ready = 1'b1;
        for (int b = 0; b < 80; b++) begin
            dump_len = 16'($urandom_range(0, 5));
            shift    = 6'($urandom_range(0, 4));
            send(16'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0));
        end
        send(16'($urandom), 16'($urandom), 1'b1);
        for (int k = 0; k < 500 && got_q.size() < exp_q.size(); k++) @(posedge clk);
        #1;
        rand_ready = 1'b0;
        o_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (got_q.size() != exp_q.size()) $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_total++; if (got_q[k] !== exp_q[k]) $display("FAIL rand_out[%0d] got %h exp %h", k, got_q[k], exp_q[k]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tlast();
        test_backpressure();
        test_saturate();
        test_rounding();
        test_reset_midblock();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
